// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM between NUM_REQ requesters.
// A tag pipeline matched to the ROM read latency routes each returned palette index
// back to the requester that issued the address.
module sprite_rom_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 9,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic                        vga_clk,
   input  logic                        Reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]           rom_address,
   input  logic [DATA_W-1:0]           rom_q,
   output logic [DATA_W-1:0]           rd_data,
   output logic [NUM_REQ-1:0]          rd_valid,
   output logic                        busy
);

   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ID_W-1:0]                 ptr_q, ptr_d;
   logic [ADDR_W-1:0]               rom_address_q, rom_address_d;
   logic [DATA_W-1:0]               rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0]              rd_valid_q, rd_valid_d;
   logic [ROM_LAT-1:0]              tag_vld_q, tag_vld_d;
   logic [ROM_LAT-1:0][ID_W-1:0]    tag_id_q, tag_id_d;

   logic                            win_found;
   logic [ID_W-1:0]                 win_id;
   logic [ID_W:0]                   cand;

   // Round-robin scan starting at ptr, wrapping modulo NUM_REQ
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand[ID_W-1:0];
         end
      end
   end

   // Combinational one-hot grant, suppressed during reset
   always_comb begin
      gnt = '0;
      if (win_found && !Reset) begin
         gnt[win_id] = 1'b1;
      end
   end

   // Next-state: address register, pointer, tag pipeline and read-data capture
   always_comb begin
      ptr_d         = ptr_q;
      rom_address_d = rom_address_q;
      if (win_found) begin
         rom_address_d = req_addr[win_id*ADDR_W +: ADDR_W];
         ptr_d         = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end

      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = win_found;
      tag_id_d[0]  = win_id;
      for (int unsigned s = 1; s < ROM_LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end

      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      if (tag_vld_q[ROM_LAT-1]) begin
         rd_data_d                           = rom_q;
         rd_valid_d[tag_id_q[ROM_LAT-1]]     = 1'b1;
      end
   end

   // State registers; reset discards any in-flight reads
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         ptr_q         <= '0;
         rom_address_q <= '0;
         rd_data_q     <= '0;
         rd_valid_q    <= '0;
         tag_vld_q     <= '0;
         tag_id_q      <= '0;
      end else begin
         ptr_q         <= ptr_d;
         rom_address_q <= rom_address_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         tag_vld_q     <= tag_vld_d;
         tag_id_q      <= tag_id_d;
      end
   end

   assign rom_address = rom_address_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign busy        = |tag_vld_q;

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM between NUM_REQ sprite requesters, e.g. player, balls, harpoon and background layers.
- A round-robin arbiter grants one requester per vga_clk cycle and registers its address onto the ROM address bus.
- The requester ID travels through a tag pipeline matched to the ROM read latency, so each returned palette index reaches the requester that issued it.
- Sits between the per-sprite drawing logic and the shared ROM/palette pair; the ROM is clocked on the negedge of vga_clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 12, ROM address width.
- DATA_W, 9, ROM data (palette index) width.
- ROM_LAT, 1, vga_clk posedges from rom_address update until rom_q is valid to sample (1..3).

Ports:
- vga_clk  input  1  pixel clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester read request; held until granted.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]; held stable while req[i]=1.
- gnt  output  NUM_REQ  one-hot, combinational grant for the current cycle.
- rom_address  output  ADDR_W  registered address to ROM.
- rom_q  input  DATA_W  ROM read data.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  NUM_REQ  one-hot, one cycle; marks the owner of rd_data.
- busy  output  1  high while any read is in flight in the tag pipeline.

Behaviour:
- Reset (async, Reset=1): ptr=0, rom_address=0, rd_data=0, rd_valid=0, all tag-pipeline valid bits 0, busy=0. gnt is forced 0 while Reset=1.
- Arbitration (combinational each cycle):
  - Winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - gnt[winner]=1; all other gnt bits are 0. If req=0, gnt=0.
- On the posedge ending a grant cycle:
  - rom_address <= req_addr[winner].
  - ptr <= (winner+1) mod NUM_REQ.
  - Stage 0 of the tag pipeline <= {valid=1, id=winner}.
- On the posedge ending a no-grant cycle:
  - rom_address holds its value.
  - ptr holds.
  - Stage 0 <= valid=0.
- Tag pipeline is ROM_LAT stages, shifted every posedge.
- When the last stage is valid at a posedge: rd_data <= rom_q and rd_valid <= onehot(id). Otherwise rd_valid <= 0 and rd_data holds.
- Latency: gnt high in cycle N; rd_valid/rd_data visible in cycle N+ROM_LAT+1. Throughput is one read per cycle with back-to-back grants fully pipelined.
- A requester deasserts req in the cycle after it sees gnt, or keeps req high to issue another read. It stays eligible and competes normally under round-robin.
- Fairness: with all requesters asserting continuously, each is granted exactly once every NUM_REQ cycles, in order ptr, ptr+1, ...
- Wrap: ptr after winner NUM_REQ-1 is 0.
- Single requester active: granted every cycle regardless of ptr.
- req change mid-cycle: arbitration follows the current req. There are no stale grants, because gnt is not registered.
- busy = OR of all tag-stage valid bits.
- Reset mid-operation: in-flight reads are discarded; no rd_valid pulses appear after Reset deasserts until new grants occur.
- Address width: req_addr is passed unmodified; no arithmetic in this block.

Test Plan:
- Reset: assert Reset with req=4'b1111 -> gnt=0, rom_address=0, rd_valid=0, busy=0. After release, the first grant is requester 0.
- Round-robin: req=4'b1111 held for 8 cycles with addresses 0x010/0x020/0x030/0x040 -> gnt sequence 0,1,2,3,0,1,2,3. rom_address follows one cycle later. rd_valid one-hot sequence 0,1,2,3,... with ROM model data = addr[8:0] -> rd_data 0x010,0x020,0x030,0x040.
- Wrap and skip: ptr=3, req=4'b0101 -> grant 0, then 2, then 0. Unrequested IDs never receive rd_valid.
- Latency sweep: ROM_LAT=1 and 3, single req[2] pulse at cycle 10, addr 0xABC -> rd_valid=4'b0100 exactly in cycle 12 (LAT=1) or 14 (LAT=3). busy high exactly for the cycles in between.
- Idle: req=0 for 5 cycles after traffic -> rom_address unchanged, rd_valid=0, ptr unchanged; the next req from ptr's requester wins first.
- Mid-flight reset: ROM_LAT=3, grants in cycles 5,6,7, Reset pulsed in cycle 8 -> no rd_valid in cycles 8-12. busy=0 immediately on Reset.
